// File: rtl/pe_bitserial_ctrl_if.sv
// pe_bitserial_ctrl_if
//   Bundles the controller's handshake, PE control and result bus signals.
//   slave  : controller side (pe_bitserial_ctrl).
//   master : requester / PE / consumer side.
//   Signals: start_i/in_ready_o (job request), load_o/step_o (PE control),
//            sa_done_i/pe_sum_i (PE per-bit result), res_valid_o/res_ready_i/
//            res_data_o (result handshake), busy_o, err_o/err_clr_i (timeout).
interface pe_bitserial_ctrl_if #(
  parameter int nSaCols       = 4,
  parameter int nAdderOutBits = 6,
  parameter int accWidth      = 10
);
  logic                                  start_i;
  logic                                  in_ready_o;
  logic                                  load_o;
  logic                                  step_o;
  logic                                  sa_done_i;
  logic [nSaCols-1:0][nAdderOutBits-1:0] pe_sum_i;
  logic                                  res_valid_o;
  logic                                  res_ready_i;
  logic [nSaCols-1:0][accWidth-1:0]      res_data_o;
  logic                                  busy_o;
  logic                                  err_o;
  logic                                  err_clr_i;

  modport slave (
    input  start_i, sa_done_i, pe_sum_i, res_ready_i, err_clr_i,
    output in_ready_o, load_o, step_o, res_valid_o, res_data_o, busy_o, err_o
  );

  modport master (
    output start_i, sa_done_i, pe_sum_i, res_ready_i, err_clr_i,
    input  in_ready_o, load_o, step_o, res_valid_o, res_data_o, busy_o, err_o
  );
endinterface

// File: rtl/pe_bitserial_ctrl.sv
// pe_bitserial_ctrl
//   Sequences a bit-serial PE array: loads an input vector, steps through
//   inputPrecision bits LSB first, and accumulates each column's partial sum
//   shifted by the bit weight. A pass that waits timeoutCycles without
//   sa_done_i aborts the job and raises a sticky error.
//   Ports: clk, nrst (async, active low), bus (pe_bitserial_ctrl_if.slave).
module pe_bitserial_ctrl #(
  parameter int nSaCols        = 4,
  parameter int inputPrecision = 4,
  parameter int nAdderOutBits  = 6,
  parameter int accWidth       = nAdderOutBits + inputPrecision,
  parameter int timeoutCycles  = 64
) (
  input logic               clk,
  input logic               nrst,
  pe_bitserial_ctrl_if.slave bus
);
  localparam int BCW = (inputPrecision > 1) ? $clog2(inputPrecision) : 1;
  localparam int WCW = $clog2(timeoutCycles + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_STEP, S_OUT} state_t;

  state_t                           r_state, w_next;
  logic [BCW-1:0]                   r_bit_cnt;
  logic [WCW-1:0]                   r_wcnt;
  logic                             r_err;
  logic [nSaCols-1:0][accWidth-1:0] w_acc;
  logic w_accept, w_done, w_last, w_tmo;
  logic w_in_ready, w_load, w_step, w_valid, w_busy;

  assign w_accept = (r_state == S_IDLE) && bus.start_i;
  assign w_done   = (r_state == S_WAIT) && bus.sa_done_i;
  assign w_last   = (r_bit_cnt == BCW'(inputPrecision - 1));
  // sa_done_i on the final allowed cycle still counts as done
  assign w_tmo    = (r_state == S_WAIT) && !bus.sa_done_i &&
                    (r_wcnt == WCW'(timeoutCycles - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_valid    = 1'b0;
    w_busy     = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (bus.start_i) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_load = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.sa_done_i) w_next = w_last ? S_OUT : S_STEP;
        else if (w_tmo)    w_next = S_IDLE;
      end
      S_STEP: begin
        w_step = 1'b1;
        w_next = S_WAIT;
      end
      S_OUT: begin
        w_valid = 1'b1;
        if (bus.res_ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_bit_cnt <= '0;
      r_wcnt    <= '0;
    end else if (w_accept) begin
      r_bit_cnt <= '0;
      r_wcnt    <= '0;
    end else if (r_state == S_STEP) begin
      r_wcnt <= '0;
    end else if (r_state == S_WAIT) begin
      if (bus.sa_done_i) begin
        if (!w_last) r_bit_cnt <= r_bit_cnt + 1'b1;
      end else if (w_tmo) begin
        r_bit_cnt <= '0;
        r_wcnt    <= '0;
      end else begin
        r_wcnt <= r_wcnt + 1'b1;
      end
    end
  end

  // Per-column accumulator: add partial sum weighted by the current bit.
  for (genvar c = 0; c < nSaCols; c++) begin : g_col
    logic [accWidth-1:0] r_acc;
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)                r_acc <= '0;
      else if (w_accept || w_tmo) r_acc <= '0;
      else if (w_done)          r_acc <= r_acc + (accWidth'(bus.pe_sum_i[c]) << r_bit_cnt);
    end
    assign w_acc[c] = r_acc;
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)              r_err <= 1'b0;
    else if (w_tmo)         r_err <= 1'b1;
    else if (bus.err_clr_i) r_err <= 1'b0;
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.load_o      = w_load;
  assign bus.step_o      = w_step;
  assign bus.res_valid_o = w_valid;
  assign bus.busy_o      = w_busy;
  assign bus.err_o       = r_err;
  assign bus.res_data_o  = w_valid ? w_acc : '0;
endmodule

// File: tb/tb_pe_bitserial_ctrl.sv
// tb_pe_bitserial_ctrl
//   Table vectors plus randomized jobs against a plain-arithmetic reference,
//   and hand-written sequences for timeout, error clear and mid-job reset.
module tb_pe_bitserial_ctrl;
  localparam int C = 4, P = 4, NB = 6, AW = 10, TO = 64;

  typedef logic [C-1:0][NB-1:0] sum_t;
  typedef logic [C-1:0][AW-1:0] data_t;
  typedef struct {
    logic [P-1:0][C-1:0][NB-1:0] sums;
    logic [P-1:0][3:0]           dly;
    bit                          spur;
    int                          hold;
    data_t                       exp_d;
    int                          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  pe_bitserial_ctrl_if #(.nSaCols(C), .nAdderOutBits(NB), .accWidth(AW)) bus();

  pe_bitserial_ctrl #(
    .nSaCols(C), .inputPrecision(P), .nAdderOutBits(NB),
    .accWidth(AW), .timeoutCycles(TO)
  ) dut (
    .clk(clk), .nrst(nrst), .bus(bus)
  );

  int   n_chk = 0, n_pass = 0, idx = 0;
  sum_t job_sum [P];
  int   job_dly [P];
  vec_t tbl [3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1; idx++;
    chk("load_step_excl", 64'(bus.load_o & bus.step_o), 64'd0);
  endtask

  function automatic sum_t rnd_sum();
    logic [31:0] r;
    r = $urandom;
    return r[C*NB-1:0];
  endfunction

  // Result = sum over bits of (partial sum * 2^bit), modulo 2^AW.
  function automatic data_t ref_result();
    data_t d;
    int    acc;
    for (int c = 0; c < C; c++) begin
      acc = 0;
      for (int b = 0; b < P; b++) acc += int'(job_sum[b][c]) * (1 << b);
      d[c] = acc[AW-1:0];
    end
    return d;
  endfunction

  // Plays the PE: reacts to load/step pulses, answers after job_dly[b] extra cycles.
  task automatic run_job(input bit spur, input int hold, output data_t data, output int lat);
    int t;
    data = '0;
    if (spur) begin
      bus.sa_done_i = 1'b1; bus.pe_sum_i = '1;
      tick();
      bus.sa_done_i = 1'b0;
    end
    bus.start_i = 1'b1; idx = 0;
    tick();
    bus.start_i = 1'b0;
    for (int b = 0; b < P; b++) begin
      t = 0;
      while ((((b == 0) ? bus.load_o : bus.step_o) !== 1'b1) && t < 8) begin tick(); t++; end
      chk((b == 0) ? "load_after_start" : "step_after_done", 64'(t), 64'd0);
      if (spur) begin bus.sa_done_i = 1'b1; bus.pe_sum_i = '1; end
      tick();
      bus.sa_done_i = 1'b0; bus.pe_sum_i = rnd_sum();
      for (int k = 0; k < job_dly[b]; k++) tick();
      bus.sa_done_i = 1'b1; bus.pe_sum_i = job_sum[b];
      tick();
      bus.sa_done_i = 1'b0; bus.pe_sum_i = rnd_sum();
      if (b < P - 1) chk("valid_early", 64'(bus.res_valid_o), 64'd0);
    end
    t = 0;
    while (bus.res_valid_o !== 1'b1 && t < 8) begin tick(); t++; end
    lat  = idx;
    data = bus.res_data_o;
    for (int h = 0; h < hold; h++) begin
      bus.res_ready_i = 1'b0; bus.start_i = (h == 2);
      tick();
      bus.start_i = 1'b0;
      chk("hold_valid_rdy", 64'({bus.res_valid_o, bus.in_ready_o}), 64'b10);
      chk("hold_data", 64'(bus.res_data_o), 64'(data));
    end
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
    chk("ack_valid_rdy", 64'({bus.res_valid_o, bus.in_ready_o}), 64'b01);
    chk("ack_data_zero", 64'(bus.res_data_o), 64'd0);
    repeat (3) begin
      tick();
      chk("no_queued_start", 64'({bus.load_o, bus.busy_o}), 64'd0);
    end
  endtask

  // Runs two good passes, then withholds sa_done_i on bit 2.
  task automatic run_timeout(input bit clr_hold);
    int t;
    bus.err_clr_i = clr_hold;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      t = 0;
      while ((((b == 0) ? bus.load_o : bus.step_o) !== 1'b1) && t < 8) begin tick(); t++; end
      chk("tmo_pulse", 64'(t), 64'd0);
      if (b < 2) begin
        tick();
        bus.sa_done_i = 1'b1; bus.pe_sum_i = rnd_sum();
        tick();
        bus.sa_done_i = 1'b0;
      end
    end
    repeat (TO) tick();
    chk("tmo_before", 64'({bus.err_o, bus.busy_o, bus.res_valid_o}), 64'b010);
    tick();
    chk("tmo_after", 64'({bus.err_o, bus.busy_o, bus.in_ready_o, bus.res_valid_o}), 64'b1010);
    bus.err_clr_i = 1'b0;
    repeat (3) begin
      tick();
      chk("tmo_no_result", 64'({bus.res_valid_o, bus.load_o, bus.err_o}), 64'b001);
    end
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    chk("err_cleared", 64'(bus.err_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    data_t d, exp_d;
    int    lat, exp_lat;

    // Vector 0: col0 1,2,3,4 -> 49; col2 5 each -> 75; col3 63 on bit3 -> 504
    // Vector 1: all 63 -> 945, with sa_done_i also pulsed in IDLE/LOAD/STEP
    // Vector 2: extra waits 1,0,2,0 -> latency 12; result held 5 cycles
    for (int b = 0; b < P; b++) begin
      tbl[0].sums[b][0] = NB'(b + 1);
      tbl[0].sums[b][1] = '0;
      tbl[0].sums[b][2] = NB'(5);
      tbl[0].sums[b][3] = (b == 3) ? NB'(63) : '0;
      tbl[1].sums[b]    = '1;
      tbl[2].sums[b][0] = (b == 0) ? NB'(10) : '0;
      tbl[2].sums[b][1] = (b == 0) ? NB'(7) : (b == 3) ? NB'(1) : '0;
      tbl[2].sums[b][2] = '0;
      tbl[2].sums[b][3] = NB'(1);
    end
    tbl[0].dly = '0; tbl[0].spur = 1'b0; tbl[0].hold = 0; tbl[0].exp_lat = 9;
    tbl[0].exp_d = {AW'(504), AW'(75), AW'(0), AW'(49)};
    tbl[1].dly = '0; tbl[1].spur = 1'b1; tbl[1].hold = 0; tbl[1].exp_lat = 9;
    tbl[1].exp_d = {AW'(945), AW'(945), AW'(945), AW'(945)};
    tbl[2].dly = {4'd0, 4'd2, 4'd0, 4'd1}; tbl[2].spur = 1'b0; tbl[2].hold = 5;
    tbl[2].exp_lat = 12;
    tbl[2].exp_d = {AW'(15), AW'(0), AW'(15), AW'(10)};

    bus.start_i = 1'b0; bus.sa_done_i = 1'b0; bus.pe_sum_i = '0;
    bus.res_ready_i = 1'b0; bus.err_clr_i = 1'b0;
    nrst = 1'b0;
    tick(); tick();
    chk("reset_outs", 64'({bus.in_ready_o, bus.load_o, bus.step_o, bus.res_valid_o,
                           bus.busy_o, bus.err_o}), 64'b100000);
    chk("reset_data", 64'(bus.res_data_o), 64'd0);
    nrst = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      for (int b = 0; b < P; b++) begin
        job_sum[b] = tbl[i].sums[b];
        job_dly[b] = int'(tbl[i].dly[b]);
      end
      run_job(tbl[i].spur, tbl[i].hold, d, lat);
      chk("tbl_data", 64'(d), 64'(tbl[i].exp_d));
      chk("tbl_latency", 64'(lat), 64'(tbl[i].exp_lat));
    end

    for (int n = 0; n < 16; n++) begin
      exp_lat = 2 + P + (P - 1);
      for (int b = 0; b < P; b++) begin
        job_sum[b] = rnd_sum();
        job_dly[b] = $urandom_range(0, 3);
        exp_lat += job_dly[b];
      end
      exp_d = ref_result();
      run_job(1'($urandom_range(0, 1)), 0, d, lat);
      chk("rnd_data", 64'(d), 64'(exp_d));
      chk("rnd_latency", 64'(lat), 64'(exp_lat));
    end

    run_timeout(1'b0);
    run_timeout(1'b1);

    // Abort during bit 1 with large partial sums; the next job must be clean.
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    bus.sa_done_i = 1'b1; bus.pe_sum_i = '1;
    tick();
    bus.sa_done_i = 1'b0;
    tick();
    nrst = 1'b0;
    #1;
    chk("midreset_outs", 64'({bus.in_ready_o, bus.load_o, bus.step_o, bus.res_valid_o,
                              bus.busy_o, bus.err_o}), 64'b100000);
    chk("midreset_data", 64'(bus.res_data_o), 64'd0);
    nrst = 1'b1;
    for (int b = 0; b < P; b++) begin
      job_sum[b] = tbl[0].sums[b];
      job_dly[b] = 0;
    end
    run_job(1'b0, 0, d, lat);
    chk("postreset_data", 64'(d), 64'(tbl[0].exp_d));
    chk("postreset_latency", 64'(lat), 64'(tbl[0].exp_lat));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
